// File: rtl/f8_sponge_ctrl.sv
// Sponge sequencer around a single F8 permutation: absorbs RATE-bit blocks,
// runs ITERS F8 passes per block and offers the digest on a valid/ready port.
module f8_sponge_ctrl #(
  parameter int unsigned RATE       = 512,
  parameter int unsigned DIGEST_W   = 256,
  parameter int unsigned ITERS      = 8,
  parameter int unsigned F8_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RATE-1:0]     in_block,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIGEST_W-1:0] out_digest,
  output logic [1023:0]       f8_state_in,
  input  logic [1023:0]       f8_state_out,
  output logic                busy
);

  localparam int unsigned STATE_W = 1024;
  localparam int unsigned LAT_W   = (F8_LATENCY > 0) ? $clog2(F8_LATENCY + 1) : 1;
  localparam int unsigned ITER_W  = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABSORB  = 2'd1,
    PERMUTE = 2'd2,
    SQUEEZE = 2'd3
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               last_q, last_d;

  // Handshake flags decode the registered FSM state; reset forces them low.
  assign in_ready    = !rst && ((fsm_q == IDLE) || (fsm_q == ABSORB));
  assign out_valid   = !rst && (fsm_q == SQUEEZE);
  assign busy        = (fsm_q != IDLE);
  assign out_digest  = state_q[DIGEST_W-1:0];
  assign f8_state_in = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      lat_q   <= '0;
      iter_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    lat_d   = lat_q;
    iter_d  = iter_q;
    last_d  = last_q;
    unique case (fsm_q)
      IDLE, ABSORB: begin
        if (in_valid && in_ready) begin
          state_d[RATE-1:0] = state_q[RATE-1:0] ^ in_block;
          last_d            = in_last;
          lat_d             = '0;
          iter_d            = '0;
          fsm_d             = PERMUTE;
        end
      end
      PERMUTE: begin
        // F8 output is taken once it has had F8_LATENCY cycles to settle.
        if (lat_q == LAT_W'(F8_LATENCY)) begin
          state_d = f8_state_out;
          lat_d   = '0;
          iter_d  = iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(ITERS - 1)) begin
            fsm_d = last_q ? SQUEEZE : ABSORB;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      SQUEEZE: begin
        if (out_ready) begin
          state_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_f8_sponge_ctrl.sv
// Self-checking bench for f8_sponge_ctrl using an increment-by-one F8 stub
// and a message-level digest model.
module tb_f8_sponge_ctrl;

  localparam int unsigned RATE  = 512;
  localparam int unsigned DW    = 256;
  localparam int unsigned ITERS = 2;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [RATE-1:0] in_block;
  logic [DW-1:0]   out_digest;
  logic [1023:0]   f8_in, f8_out;

  logic            in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, busy_b;
  logic [RATE-1:0] in_block_b;
  logic [DW-1:0]   out_digest_b;
  logic [1023:0]   f8_in_b, f8_out_b;

  int n_cmp = 0;
  int n_err = 0;
  int acc_mon = 0;
  logic [RATE-1:0] msg[$];

  f8_sponge_ctrl #(.RATE(RATE), .DIGEST_W(DW), .ITERS(ITERS), .F8_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
    .f8_state_in(f8_in), .f8_state_out(f8_out), .busy(busy));

  f8_sponge_ctrl #(.RATE(RATE), .DIGEST_W(DW), .ITERS(1), .F8_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
    .in_last(in_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_digest(out_digest_b),
    .f8_state_in(f8_in_b), .f8_state_out(f8_out_b), .busy(busy_b));

  // F8 stubs: +1 on the whole state, one-cycle delay for dut, combinational for dut_b
  always @(posedge clk) f8_out <= f8_in + 1024'd1;
  assign f8_out_b = f8_in_b + 1024'd1;

  always @(posedge clk) if (!rst && in_valid && in_ready) acc_mon <= acc_mon + 1;

  // Digest of the message in msg: absorb each block, then ITERS increments.
  function automatic logic [DW-1:0] model_digest(input int iters);
    logic [1023:0] s;
    s = '0;
    foreach (msg[i]) begin
      s[RATE-1:0] = s[RATE-1:0] ^ msg[i];
      s = s + 1024'(iters);
    end
    return s[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic checki(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer a block after 'gap' idle cycles; returns once it has been accepted.
  task automatic send(input logic [RATE-1:0] b, input bit last, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_block = b; in_last = last;
    for (int c = 0; c < 200 && !done; c++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) checkb("send_timeout", 1'b0, 1'b1);
    msg.push_back(b);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) checkb("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int gap);
    repeat (gap) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_b = 1'b0; out_ready_b = 1'b0;
    tick();
    tick();
    checkb("rst_in_ready_low", in_ready, 1'b0);
    checkb("rst_out_valid_low", out_valid, 1'b0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    int a0;
    bit ok;
    logic [DW-1:0] d0;
    logic [RATE-1:0] blk;
    logic [RATE-1:0] b5[3];

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_block = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_last_b = 1'b0; in_block_b = '0; out_ready_b = 1'b0;
    do_reset();
    checkb("reset_in_ready", in_ready, 1'b1);
    checkb("reset_out_valid", out_valid, 1'b0);
    checkb("reset_busy", busy, 1'b0);
    check("reset_digest", out_digest, '0);
    checkb("reset_state_zero", f8_in == '0, 1'b1);

    // out_ready high while idle is harmless
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checkb("idle_out_ready_busy", busy, 1'b0);
    checkb("idle_out_ready_valid", out_valid, 1'b0);

    // 1: single block
    msg.delete();
    send(512'd2500, 1'b1, 0);
    wait_valid(n);
    checki("t1_latency", n, 4);
    check("t1_digest", out_digest, 256'd2502);
    drain(0);

    // 2: two blocks
    msg.delete();
    send(512'd5, 1'b0, 0);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    checki("t2_ready_gap", n, 4);
    checkb("t2_absorb_busy", busy, 1'b1);
    send(512'd3, 1'b1, 0);
    wait_valid(n);
    check("t2_digest", out_digest, 256'd6);

    // 3: backpressure in SQUEEZE
    d0 = out_digest;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_digest !== d0 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    checkb("t3_held_stable", ok, 1'b1);
    check("t3_digest_held", out_digest, 256'd6);
    drain(0);
    checkb("t3_idle", busy, 1'b0);
    checkb("t3_state_zero", f8_in == '0, 1'b1);
    checkb("t3_in_ready", in_ready, 1'b1);

    // 4: reset during second PERMUTE cycle
    msg.delete();
    send(512'd7, 1'b1, 0);
    tick();
    rst = 1'b1;
    #1;
    checkb("t4_rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkb("t4_busy", busy, 1'b0);
    checkb("t4_out_valid", out_valid, 1'b0);
    check("t4_digest_zero", out_digest, '0);
    msg.delete();
    send(512'd1, 1'b1, 0);
    wait_valid(n);
    check("t4_new_digest", out_digest, 256'd3);
    drain(1);

    // 5: in_valid held high through PERMUTE; each block taken exactly once
    msg.delete();
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom;
      b5[i] = blk;
      msg.push_back(blk);
    end
    a0 = acc_mon;
    n = 0;
    in_valid = 1'b1; in_block = b5[0]; in_last = 1'b0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      ok = in_ready;
      tick();
      if (ok) begin
        n++;
        if (n < 3) begin in_block = b5[n]; in_last = (n == 2); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_valid(n);
    checki("t5_accepts", acc_mon - a0, 3);
    check("t5_digest", out_digest, model_digest(ITERS));
    drain(2);

    // 6: zero-latency, single-iteration instance
    in_valid_b = 1'b1; in_block_b = 512'd9; in_last_b = 1'b1;
    checkb("t6_ready", in_ready_b, 1'b1);
    tick();
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 50) begin tick(); n++; end
    checki("t6_latency", n, 1);
    check("t6_digest", out_digest_b, 256'd10);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    checkb("t6_idle", busy_b, 1'b0);

    // Random messages against the model
    for (int m = 0; m < 8; m++) begin
      int len;
      msg.delete();
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom;
        send(blk, k == len - 1, $urandom_range(0, 2));
      end
      wait_valid(n);
      check($sformatf("rand_digest_%0d", m), out_digest, model_digest(ITERS));
      drain($urandom_range(0, 3));
      checkb($sformatf("rand_idle_%0d", m), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
